// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue sequencer.
// Holds funct codes, the TotalALU control encodings and the sequencer state type.
package alu_pkg;

  localparam logic [5:0] FUNCT_AND   = 6'd36;
  localparam logic [5:0] FUNCT_OR    = 6'd37;
  localparam logic [5:0] FUNCT_ADD   = 6'd32;
  localparam logic [5:0] FUNCT_SUB   = 6'd34;
  localparam logic [5:0] FUNCT_SLT   = 6'd42;
  localparam logic [5:0] FUNCT_SLL   = 6'd0;
  localparam logic [5:0] FUNCT_SRL   = 6'd2;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;

  localparam logic [2:0] CTRL_AND  = 3'b000;
  localparam logic [2:0] CTRL_OR   = 3'b001;
  localparam logic [2:0] CTRL_ADD  = 3'b010;
  localparam logic [2:0] CTRL_SUB  = 3'b110;
  localparam logic [2:0] CTRL_SLT  = 3'b111;
  localparam logic [2:0] CTRL_NONE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MCLR,
    ST_MRUN,
    ST_MFHI,
    ST_RESP_HI,
    ST_MFLO,
    ST_RESP
  } seq_state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational MIPS funct decoder: TotalALU control code, legality and
// whether the op needs the multi-cycle multiply sequence.
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] control,
  output logic       legal,
  output logic       is_mult
);

  always_comb begin
    control = CTRL_NONE;
    legal   = 1'b1;
    is_mult = 1'b0;
    case (funct)
      FUNCT_AND:   control = CTRL_AND;
      FUNCT_OR:    control = CTRL_OR;
      FUNCT_ADD:   control = CTRL_ADD;
      FUNCT_SUB:   control = CTRL_SUB;
      FUNCT_SLT:   control = CTRL_SLT;
      FUNCT_SLL:   control = CTRL_NONE;
      FUNCT_SRL:   control = CTRL_NONE;
      FUNCT_MULTU: is_mult = 1'b1;
      default:     legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage in front of TotalALU; sequences MULTU as clear, run, MFHI, MFLO.
// Optional perf counters are enabled by defining ALU_SEQ_PERF_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 32,
  parameter int ALU_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [5:0]        op_funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] alu_dataA,
  output logic [DATA_W-1:0] alu_dataB,
  output logic [5:0]        alu_signal,
  output logic [2:0]        alu_control,
  output logic              alu_reset,
  input  logic [DATA_W-1:0] alu_output,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_hi,
  output logic              err_illegal
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_busy
`endif
);

  localparam int CNT_MAX = (MULT_CYCLES > ALU_LAT) ? MULT_CYCLES : ALU_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);

  seq_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             clr;
  logic [2:0]       dec_control;
  logic             dec_legal, dec_is_mult;
  logic             accept, cnt_zero;

  alu_funct_decode u_dec (
    .funct   (op_funct),
    .control (dec_control),
    .legal   (dec_legal),
    .is_mult (dec_is_mult)
  );

  assign accept    = op_valid && (state == ST_IDLE);
  assign cnt_zero  = (cnt == CNT_W'(0));
  assign op_ready  = (state == ST_IDLE);
  assign alu_reset = reset | clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!accept)          state_nxt = ST_IDLE;
        else if (!dec_legal)  state_nxt = ST_IDLE;
        else if (dec_is_mult) state_nxt = ST_MCLR;
        else                  state_nxt = ST_EXEC;
      end
      ST_EXEC:    if (cnt_zero) state_nxt = ST_RESP;    else state_nxt = ST_EXEC;
      ST_MCLR:    state_nxt = ST_MRUN;
      ST_MRUN:    if (cnt_zero) state_nxt = ST_MFHI;    else state_nxt = ST_MRUN;
      ST_MFHI:    if (cnt_zero) state_nxt = ST_RESP_HI; else state_nxt = ST_MFHI;
      ST_RESP_HI: if (res_ready) state_nxt = ST_MFLO;   else state_nxt = ST_RESP_HI;
      ST_MFLO:    if (cnt_zero) state_nxt = ST_RESP;    else state_nxt = ST_MFLO;
      ST_RESP:    if (res_ready) state_nxt = ST_IDLE;   else state_nxt = ST_RESP;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // One counter serves every timed state; it is reloaded on each state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= CNT_W'(0);
    end else if (state_nxt != state) begin
      case (state_nxt)
        ST_EXEC, ST_MFHI, ST_MFLO: cnt <= LAT_LOAD;
        ST_MRUN:                   cnt <= MULT_LOAD;
        default:                   cnt <= CNT_W'(0);
      endcase
    end else if (!cnt_zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_dataA   <= {DATA_W{1'b0}};
      alu_dataB   <= {DATA_W{1'b0}};
      alu_signal  <= 6'd0;
      alu_control <= 3'd0;
      clr         <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= {DATA_W{1'b0}};
      res_hi      <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= accept && !dec_legal;
      clr         <= accept && dec_legal && dec_is_mult;
      res_valid   <= (state_nxt == ST_RESP) || (state_nxt == ST_RESP_HI);
      if (accept && dec_legal) begin
        alu_dataA   <= op_a;
        alu_dataB   <= op_b;
        alu_signal  <= op_funct;
        alu_control <= dec_control;
      end else if ((state == ST_MRUN) && cnt_zero) begin
        alu_signal  <= FUNCT_MFHI;
      end else if ((state == ST_RESP_HI) && res_ready) begin
        alu_signal  <= FUNCT_MFLO;
      end
      if (((state == ST_EXEC) || (state == ST_MFLO)) && cnt_zero) begin
        res_data <= alu_output;
        res_hi   <= 1'b0;
      end else if ((state == ST_MFHI) && cnt_zero) begin
        res_data <= alu_output;
        res_hi   <= 1'b1;
      end
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // Saturating activity counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ops  <= 32'd0;
      perf_busy <= 32'd0;
    end else begin
      if (accept && dec_legal && (perf_ops != 32'hFFFF_FFFF)) perf_ops <= perf_ops + 32'd1;
      if ((state != ST_IDLE) && (perf_busy != 32'hFFFF_FFFF)) perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule
